// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined ALU with valid/ready handshake, accumulate mode and a consumed-result counter.
// OpCode: 00 sub, 01 add, 10 OR, 11 AND; Flags = {N,Z,C,V,P}.
module alu_pipe_acc #(
  parameter int M     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     A,
  input  logic [M-1:0]     B,
  input  logic [1:0]       OpCode,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     Result,
  output logic [4:0]       Flags,
  output logic [CNT_W-1:0] op_count
);

  logic [M-1:0]     r_s1_a, r_s1_b;
  logic [1:0]       r_s1_op;
  logic             r_s1_acc, r_s1_valid;
  logic [M-1:0]     r_result;
  logic [4:0]       r_flags;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_op_count;

  logic             w_adv2, w_accept, w_consume;
  logic [M-1:0]     w_opa, w_res;
  logic [M:0]       w_ext;
  logic             w_c, w_v;
  logic [4:0]       w_flags;

  assign w_adv2    = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_adv2;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_out_valid & out_ready;

  // Accumulate reads the Result register, which was written on the previous adv2 edge.
  assign w_opa = r_s1_acc ? r_result : r_s1_a;

  always_comb begin
    w_ext = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_s1_op)
      2'b00: begin
        w_ext = {1'b0, w_opa} - {1'b0, r_s1_b};
        w_c   = w_ext[M];
        w_v   = (w_opa[M-1] != r_s1_b[M-1]) & (w_ext[M-1] != w_opa[M-1]);
      end
      2'b01: begin
        w_ext = {1'b0, w_opa} + {1'b0, r_s1_b};
        w_c   = w_ext[M];
        w_v   = (w_opa[M-1] == r_s1_b[M-1]) & (w_ext[M-1] != w_opa[M-1]);
      end
      2'b10:   w_ext = {1'b0, w_opa | r_s1_b};
      default: w_ext = {1'b0, w_opa & r_s1_b};
    endcase
    w_res   = w_ext[M-1:0];
    w_flags = {w_res[M-1], (w_res == '0), w_c, w_v, ^w_res};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= '0;
      r_s1_acc    <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_s1_a     <= A;
        r_s1_b     <= B;
        r_s1_op    <= OpCode;
        r_s1_acc   <= acc_en;
        r_s1_valid <= 1'b1;
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv2) begin
        r_result    <= w_res;
        r_flags     <= w_flags;
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end

      if (w_consume) r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign Result    = r_result;
  assign Flags     = r_flags;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Bench for alu_pipe_acc: directed literal cases plus randomized traffic against a queue-based model.
module tb_alu_pipe_acc;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, acc_en = 1'b0, out_ready = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [1:0] OpCode = '0;
  logic       in_ready, out_valid, in_ready2, out_valid2;
  logic [3:0] Result, Result2;
  logic [4:0] Flags, Flags2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  int checks = 0, errors = 0;

  alu_pipe_acc #(.M(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .OpCode(OpCode), .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Flags(Flags), .op_count(op_count));

  alu_pipe_acc #(.M(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B),
    .OpCode(OpCode), .acc_en(acc_en), .out_valid(out_valid2), .out_ready(out_ready),
    .Result(Result2), .Flags(Flags2), .op_count(op_count2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers: returns {Result, N,Z,C,V,P}.
  function automatic logic [8:0] calc(input int a, input int b, input int op);
    int full, half, sa, sb, r, sv, res;
    logic c, v;
    full = 1 << M; half = full / 2;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    c = 0; v = 0; sv = 0;
    case (op)
      0: begin r = a - b; c = (a < b); sv = sa - sb; v = (sv < -half) || (sv >= half); end
      1: begin r = a + b; c = (r >= full); sv = sa + sb; v = (sv < -half) || (sv >= half); end
      2: r = a | b;
      default: r = a & b;
    endcase
    res = ((r % full) + full) % full;
    calc = {4'(res), (res >= half), (res == 0), c, v, 1'($countones(res) % 2)};
  endfunction

  typedef struct { int a; int b; int op; bit acc; } op_t;
  op_t mq[$];
  bit  m_ov;
  int  m_res, m_flg, m_cnt;

  function automatic bit m_ready();
    return (mq.size() == 0) || !m_ov || out_ready;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); m_ov = 0; m_res = 0; m_flg = 0; m_cnt = 0;
    end else begin
      bit rdy, cons, mv;
      op_t o;
      logic [8:0] rf;
      rdy  = m_ready();
      cons = m_ov && out_ready;
      mv   = (mq.size() > 0) && (!m_ov || out_ready);
      if (cons) m_cnt++;
      if (mv) begin
        o  = mq.pop_front();
        rf = calc(o.acc ? m_res : o.a, o.b, o.op);
        m_res = int'(rf[8:5]); m_flg = int'(rf[4:0]); m_ov = 1;
      end else if (cons) m_ov = 0;
      if (in_valid && rdy) begin
        o.a = int'(A); o.b = int'(B); o.op = int'(OpCode); o.acc = acc_en;
        mq.push_back(o);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
      chk("cmp_result", 32'(Result), m_res);
      chk("cmp_flags", 32'(Flags), m_flg);
      chk("cmp_op_count", 32'(op_count), m_cnt % 256);
      chk("cmp_op_count2", 32'(op_count2), m_cnt % 4);
      chk("cmp2_rdy_vld", {in_ready2, out_valid2}, {in_ready, out_valid});
      chk("cmp2_res_flg", {Result2, Flags2}, {Result, Flags});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input int a, input int b, input int op, input bit acc);
    bit done, rdy;
    A = 4'(a); B = 4'(b); OpCode = 2'(op); acc_en = acc; in_valid = 1;
    done = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic op_chk(input string name, input int a, input int b, input int op,
                        input logic [3:0] er, input logic [4:0] ef);
    send(a, b, op, 0);
    in_valid = 0;
    chk({name, "_lat_s1"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    chk({name, "_vld"}, 32'(out_valid), 1);
    chk({name, "_res"}, 32'(Result), 32'(er));
    chk({name, "_flg"}, 32'(Flags), 32'(ef));
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_outs", {out_valid, Result, Flags, op_count}, 0);
  endtask

  initial begin
    int pa[3], pb[3], po[3], nacc, got;
    int rq[$];
    bit r;

    chk("model_add_7_1",   32'(calc(7, 1, 1)),    {23'd0, 4'b1000, 5'b10011});
    chk("model_add_f_f",   32'(calc(15, 15, 1)),  {23'd0, 4'b1110, 5'b10101});
    chk("model_sub_0_1",   32'(calc(0, 1, 0)),    {23'd0, 4'b1111, 5'b10100});
    chk("model_sub_8_6",   32'(calc(8, 6, 0)),    {23'd0, 4'b0010, 5'b00011});
    chk("model_and_a_5",   32'(calc(10, 5, 3)),   {23'd0, 4'b0000, 5'b01000});
    chk("model_or_4_a",    32'(calc(4, 10, 2)),   {23'd0, 4'b1110, 5'b10001});

    repeat (3) @(posedge clk); #1;
    do_reset();
    out_ready = 1;

    op_chk("add_7_1", 7, 1, 1, 4'b1000, 5'b10011);
    op_chk("add_f_f", 15, 15, 1, 4'b1110, 5'b10101);
    op_chk("sub_0_1", 0, 1, 0, 4'b1111, 5'b10100);
    op_chk("sub_8_6", 8, 6, 0, 4'b0010, 5'b00011);
    op_chk("and_a_5", 10, 5, 3, 4'b0000, 5'b01000);
    op_chk("or_4_a", 4, 10, 2, 4'b1110, 5'b10001);

    // Back-to-back accumulate chain: 3+1, +2, -6.
    send(3, 1, 1, 0);
    send(0, 2, 1, 1);
    chk("acc1_res", 32'(Result), 4);
    send(0, 6, 0, 1);
    chk("acc2_res", 32'(Result), 6);
    in_valid = 0;
    @(posedge clk); #1;
    chk("acc3_res", 32'(Result), 0);
    chk("acc3_flg", 32'(Flags), 32'(5'b01000));
    repeat (3) @(posedge clk); #1;
    chk("acc_hold", 32'(Result), 0);

    // Backpressure: three offers with out_ready low, only two fit.
    do_reset();
    out_ready = 0;
    pa = '{1, 2, 12}; pb = '{1, 3, 10}; po = '{1, 1, 3};
    nacc = 0;
    for (int c = 0; c < 3; c++) begin
      A = 4'(pa[nacc]); B = 4'(pb[nacc]); OpCode = 2'(po[nacc]); acc_en = 0; in_valid = 1;
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) nacc++;
    end
    chk("bp_accepted", nacc, 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_result_held", 32'(Result), 2);
    out_ready = 1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (nacc < 3) begin A = 4'(pa[nacc]); B = 4'(pb[nacc]); OpCode = 2'(po[nacc]); end
      @(negedge clk); r = in_ready;
      if (out_valid) begin rq.push_back(int'(Result)); got++; end
      @(posedge clk); #1;
      if (r && in_valid) begin nacc++; if (nacc == 3) in_valid = 0; end
    end
    in_valid = 0;
    chk("bp_count_out", rq.size(), 3);
    if (rq.size() == 3) begin
      chk("bp_order0", rq[0], 2);
      chk("bp_order1", rq[1], 5);
      chk("bp_order2", rq[2], 8);
    end
    chk("bp_op_count", 32'(op_count), 3);
    chk("bp_op_count2", 32'(op_count2), 3);

    // Counter wrap on the 2-bit instance: 3 -> 0 -> 1.
    op_chk("wrap_a", 1, 1, 1, 4'b0010, 5'b00001);
    @(posedge clk); #1;
    chk("wrap_cnt2_0", 32'(op_count2), 0);
    chk("wrap_cnt8_4", 32'(op_count), 4);
    op_chk("wrap_b", 5, 0, 2, 4'b0101, 5'b00000);
    @(posedge clk); #1;
    chk("wrap_cnt2_1", 32'(op_count2), 1);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A = 4'($urandom); B = 4'($urandom); OpCode = 2'($urandom);
      acc_en = ($urandom_range(0, 2) == 0);
      if (c == 700) begin
        #1 reset = 1;
        #1;
        chk("async_rst_outs", {out_valid, Result, Flags, op_count}, 0);
        chk("async_rst_cnt2", 32'(op_count2), 0);
        #1 reset = 0;
        chk("async_rst_ready", 32'(in_ready), 1);
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
